// File: rtl/instr_fetch.sv
// Fetch stage: program counter plus loadable instruction memory. It issues one
// registered instruction per unstalled cycle and resolves JMP and HALT locally.
`ifndef ISIZE
`define ISIZE 15
`endif

module instr_fetch #(
  parameter int         AW      = 8,
  parameter logic [3:0] HALT_OP = 4'hF,
  parameter logic [3:0] JMP_OP  = 4'hE
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              LoadEn,
  input  logic [AW-1:0]     LoadAddr,
  input  logic [`ISIZE:0]   LoadData,
  input  logic              Stall,
  output logic [`ISIZE:0]   Instruction,
  output logic              InstrValid,
  output logic [AW-1:0]     PC,
  output logic              Halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     pc_next;
  logic [`ISIZE:0]   instr_next;
  logic              valid_next;
  logic              halted_next;
  logic              mem_we;
  logic [`ISIZE:0]   word;
  logic [3:0]        opcode;

  logic [`ISIZE:0]   mem [2**AW];

  // The word at PC is read combinationally so a fetch completes in one cycle.
  assign word   = mem[PC];
  assign opcode = word[`ISIZE -: 4];

  // Program loading is only allowed while the stage is not running.
  assign mem_we = LoadEn && (state != RUN);

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[LoadAddr] <= LoadData;
    end
  end

  // Next-state and next-output logic; everything holds unless a rule fires.
  always_comb begin
    state_next  = state;
    pc_next     = PC;
    instr_next  = Instruction;
    valid_next  = InstrValid;
    halted_next = Halted;
    case (state)
      IDLE, HALT: begin
        valid_next = 1'b0;
        if (Start) begin
          state_next  = RUN;
          pc_next     = '0;
          halted_next = 1'b0;
        end
      end
      RUN: begin
        if (!Stall) begin
          if (opcode == JMP_OP) begin
            pc_next    = word[AW-1:0];
            valid_next = 1'b0;
          end else if (opcode == HALT_OP) begin
            state_next  = HALT;
            halted_next = 1'b1;
            valid_next  = 1'b0;
          end else begin
            instr_next = word;
            valid_next = 1'b1;
            pc_next    = PC + AW'(1);
          end
        end
      end
      default: begin
        state_next  = IDLE;
        pc_next     = '0;
        valid_next  = 1'b0;
        halted_next = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      PC          <= '0;
      Instruction <= '0;
      InstrValid  <= 1'b0;
      Halted      <= 1'b0;
    end else begin
      state       <= state_next;
      PC          <= pc_next;
      Instruction <= instr_next;
      InstrValid  <= valid_next;
      Halted      <= halted_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the fetch rules.
module tb_instr_fetch;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic        LoadEn;
  logic [7:0]  LoadAddr;
  logic [15:0] LoadData;
  logic        Stall;
  logic [15:0] Instruction;
  logic        InstrValid;
  logic [7:0]  PC;
  logic        Halted;

  int checks = 0;
  int passes = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = halted.
  logic [15:0] mmem [256];
  int          mmode;
  int          mpc;
  logic [15:0] minstr;
  logic        mvalid;

  instr_fetch dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .LoadEn      (LoadEn),
    .LoadAddr    (LoadAddr),
    .LoadData    (LoadData),
    .Stall       (Stall),
    .Instruction (Instruction),
    .InstrValid  (InstrValid),
    .PC          (PC),
    .Halted      (Halted)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock edge using the inputs that were applied.
  task automatic modelEdge(input logic st, input logic ld, input logic [7:0] la,
                           input logic [15:0] lw, input logic sl);
    logic [15:0] w;
    if (mmode != 1) begin
      if (ld) mmem[la] = lw;
      mvalid = 1'b0;
      if (st) begin
        mmode = 1;
        mpc   = 0;
      end
    end else if (!sl) begin
      w = mmem[mpc];
      if (w[15:12] == 4'hE) begin
        mpc    = w[7:0];
        mvalid = 1'b0;
      end else if (w[15:12] == 4'hF) begin
        mmode  = 2;
        mvalid = 1'b0;
      end else begin
        minstr = w;
        mvalid = 1'b1;
        mpc    = (mpc + 1) % 256;
      end
    end
  endtask

  // Compares every DUT output with the model.
  task automatic compareModel(input string tag);
    checkOutput({tag, "_instr"},  32'(Instruction), 32'(minstr));
    checkOutput({tag, "_valid"},  32'(InstrValid),  32'(mvalid));
    checkOutput({tag, "_pc"},     32'(PC),          32'(mpc));
    checkOutput({tag, "_halted"}, 32'(Halted),      32'(mmode == 2));
  endtask

  // Drives one cycle of inputs, clocks the DUT and model, then compares.
  task automatic applyStimulus(input logic st, input logic ld, input logic [7:0] la,
                               input logic [15:0] lw, input logic sl, input string tag);
    Start    = st;
    LoadEn   = ld;
    LoadAddr = la;
    LoadData = lw;
    Stall    = sl;
    @(posedge Clock);
    modelEdge(st, ld, la, lw, sl);
    #1;
    compareModel(tag);
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    applyStimulus(1'b0, 1'b1, a, d, 1'b0, "load");
  endtask

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic asyncReset(input string tag);
    #2;
    Reset = 1'b0;
    #1;
    mmode  = 0;
    mpc    = 0;
    minstr = '0;
    mvalid = 1'b0;
    checkOutput({tag, "_instr0"}, 32'(Instruction), 32'h0);
    checkOutput({tag, "_valid0"}, 32'(InstrValid),  32'h0);
    checkOutput({tag, "_pc0"},    32'(PC),          32'h0);
    checkOutput({tag, "_halt0"},  32'(Halted),      32'h0);
    #2;
    Reset = 1'b1;
  endtask

  initial begin
    Reset    = 1'b0;
    Start    = 1'b0;
    LoadEn   = 1'b0;
    LoadAddr = '0;
    LoadData = '0;
    Stall    = 1'b0;
    mmode    = 0;
    mpc      = 0;
    minstr   = '0;
    mvalid   = 1'b0;
    #3;
    compareModel("reset");
    #4;
    Reset = 1'b1;

    // Fill the whole memory so the model and DUT agree on every word.
    for (int i = 0; i < 256; i++) load(8'(i), 16'($urandom));

    // Straight-line program ending in HALT.
    load(8'h00, 16'h1123);
    load(8'h01, 16'h2456);
    load(8'h02, 16'hF000);
    applyStimulus(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, "t1_start");
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t1_a");
    checkOutput("t1_first", 32'(Instruction), 32'h1123);
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t1_b");
    checkOutput("t1_second", 32'(Instruction), 32'h2456);
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t1_c");
    checkOutput("t1_halted", 32'(Halted), 32'h1);
    checkOutput("t1_pc", 32'(PC), 32'h2);

    // Reload while halted, restart, and stall on the second instruction.
    load(8'h00, 16'h4111);
    load(8'h02, 16'h3333);
    load(8'h03, 16'hF000);
    applyStimulus(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, "t6_start");
    checkOutput("t6_unhalt", 32'(Halted), 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t6_a");
    checkOutput("t6_first", 32'(Instruction), 32'h4111);
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t3_a");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h01, 16'h0BAD, 1'b1, "t3_stall");
      checkOutput("t3_hold_instr", 32'(Instruction), 32'h2456);
      checkOutput("t3_hold_pc", 32'(PC), 32'h2);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t3_release");
    checkOutput("t3_next", 32'(Instruction), 32'h3333);
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t3_halt");

    // Jump with a single bubble.
    load(8'h00, 16'hE005);
    load(8'h05, 16'h3789);
    load(8'h06, 16'hF000);
    applyStimulus(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, "t2_start");
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t2_bubble");
    checkOutput("t2_bubble_valid", 32'(InstrValid), 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t2_target");
    checkOutput("t2_instr", 32'(Instruction), 32'h3789);
    checkOutput("t2_pc", 32'(PC), 32'h6);
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t2_halt");

    // PC wrap from the top of memory.
    load(8'h00, 16'h2002);
    load(8'h01, 16'hE0FF);
    load(8'hFF, 16'h1001);
    applyStimulus(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, "t4_start");
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t4_a");
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t4_jmp");
    checkOutput("t4_pc_ff", 32'(PC), 32'hFF);
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t4_b");
    checkOutput("t4_top", 32'(Instruction), 32'h1001);
    checkOutput("t4_pc_0", 32'(PC), 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t4_c");
    checkOutput("t4_wrap", 32'(Instruction), 32'h2002);
    checkOutput("t4_pc_1", 32'(PC), 32'h1);

    // Asynchronous reset mid-run; loads while running must be ignored.
    asyncReset("t5");
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t5_idle");
    applyStimulus(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, "t5_start");
    applyStimulus(1'b0, 1'b1, 8'h00, 16'h7777, 1'b1, "t5_ld_run");
    asyncReset("t5b");
    applyStimulus(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, "t5_restart");
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, "t5_first");
    checkOutput("t5_mem_kept", 32'(Instruction), 32'h2002);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        asyncReset("rnd_rst");
      end else begin
        applyStimulus(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
                      8'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0), "rnd");
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
